// File: rtl/sphere_hit_scanner.sv
// sphere_hit_scanner
// Scans the four spheres through the Read_index/Sphere_pos read port, tests each
// against a captured 2-D aim point and raises Hit/Hit_index for the nearest
// sphere inside the hit radius. Hit is held until a Frame_Clk rising edge.
// Optional build macro SPHERE_HIT_SCORE_EN adds a saturating 16-bit Score output
// counting consumed hits.
module sphere_hit_scanner #(
  parameter int RADIUS    = 240,
  parameter int DEPTH_MAX = 8000
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Frame_Clk,
  input  logic         Fire,
  input  logic [15:0]  Aim_x,
  input  logic [15:0]  Aim_z,
  input  logic [191:0] Sphere_pos,
  input  logic [1:0]   curr_index,
  output logic [1:0]   Read_index,
  output logic         Hit,
  output logic [1:0]   Hit_index,
  output logic         Busy
`ifdef SPHERE_HIT_SCORE_EN
  ,
  output logic [15:0]  Score
`endif
);

  localparam logic [34:0]        RAD_SQ    = 35'(RADIUS * RADIUS);
  localparam logic signed [15:0] DEPTH_LIM = 16'(DEPTH_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] aim_x_r, aim_x_s;
  logic [15:0] aim_z_r, aim_z_s;
  logic        issue_r, issue_s;      // a read is on the port this cycle
  logic        valid_r, valid_s;      // returned sample is present this cycle
  logic        best_vld_r, best_vld_s;
  logic [34:0] best_sum_r, best_sum_s;
  logic [1:0]  best_idx_r, best_idx_s;
  logic        frame_prev_r;
  logic [1:0]  read_index_s;
  logic        hit_s;
  logic [1:0]  hit_index_s;
  logic        busy_s;
`ifdef SPHERE_HIT_SCORE_EN
  logic [15:0] score_s;
`endif

  // Distance datapath: integer parts only, widened so nothing wraps.
  logic signed [15:0] x_s, z_s, depth_s;
  logic signed [16:0] dx_s, dz_s;
  logic signed [33:0] dx_w_s, dz_w_s, sq_x_s, sq_z_s;
  logic [34:0]        sum_s;
  logic               cand_s, better_s, frame_rise_s;

  assign x_s     = Sphere_pos[47:32];
  assign depth_s = Sphere_pos[111:96];
  assign z_s     = Sphere_pos[175:160];
  assign dx_s    = {x_s[15], x_s} - {aim_x_r[15], aim_x_r};
  assign dz_s    = {z_s[15], z_s} - {aim_z_r[15], aim_z_r};
  assign dx_w_s  = {{17{dx_s[16]}}, dx_s};
  assign dz_w_s  = {{17{dz_s[16]}}, dz_s};
  // |d| <= 65535, so the square fits below 2^32 and the low 34 bits are exact.
  assign sq_x_s  = dx_w_s * dx_w_s;
  assign sq_z_s  = dz_w_s * dz_w_s;
  assign sum_s   = {1'b0, sq_x_s} + {1'b0, sq_z_s};
  assign cand_s  = (sum_s < RAD_SQ) && (depth_s <= DEPTH_LIM);
  // Strictly smaller wins; scan order 0..3 makes ties go to the lower index.
  assign better_s = cand_s && (!best_vld_r || (sum_s < best_sum_r));
  assign frame_rise_s = Frame_Clk && !frame_prev_r;

  // Next-state and next-output logic for the scan controller.
  always_comb begin
    state_s      = state_r;
    aim_x_s      = aim_x_r;
    aim_z_s      = aim_z_r;
    issue_s      = issue_r;
    valid_s      = issue_r;
    best_vld_s   = best_vld_r;
    best_sum_s   = best_sum_r;
    best_idx_s   = best_idx_r;
    read_index_s = Read_index;
    hit_s        = Hit;
    hit_index_s  = Hit_index;
`ifdef SPHERE_HIT_SCORE_EN
    score_s      = Score;
`endif
    case (state_r)
      IDLE: begin
        read_index_s = 2'd0;
        issue_s      = 1'b0;
        hit_s        = 1'b0;
        if (Fire) begin
          aim_x_s    = Aim_x;
          aim_z_s    = Aim_z;
          best_vld_s = 1'b0;
          best_sum_s = 35'd0;
          best_idx_s = 2'd0;
          issue_s    = 1'b1;
          state_s    = SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (issue_r) begin
          if (Read_index == 2'd3) begin
            issue_s      = 1'b0;
            read_index_s = 2'd0;
          end else begin
            read_index_s = Read_index + 2'd1;
          end
        end else begin
          read_index_s = 2'd0;
        end
        if (valid_r) begin
          if (better_s) begin
            best_vld_s = 1'b1;
            best_sum_s = sum_s;
            best_idx_s = curr_index;
          end else begin
            best_vld_s = best_vld_r;
          end
          if (curr_index == 2'd3) begin
            if (better_s || best_vld_r) begin
              hit_s       = 1'b1;
              hit_index_s = better_s ? curr_index : best_idx_r;
              state_s     = HOLD;
            end else begin
              state_s = IDLE;
            end
          end else begin
            state_s = SCAN;
          end
        end else begin
          state_s = SCAN;
        end
      end
      HOLD: begin
        read_index_s = 2'd0;
        issue_s      = 1'b0;
        if (frame_rise_s) begin
          hit_s   = 1'b0;
          state_s = IDLE;
`ifdef SPHERE_HIT_SCORE_EN
          if (Score != 16'hFFFF) begin
            score_s = Score + 16'd1;
          end else begin
            score_s = Score;
          end
`endif
        end else begin
          hit_s = 1'b1;
        end
      end
      default: begin
        state_s      = IDLE;
        read_index_s = 2'd0;
        issue_s      = 1'b0;
        valid_s      = 1'b0;
        hit_s        = 1'b0;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, tracker and registered outputs; Reset clears everything at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r      <= IDLE;
      aim_x_r      <= 16'd0;
      aim_z_r      <= 16'd0;
      issue_r      <= 1'b0;
      valid_r      <= 1'b0;
      best_vld_r   <= 1'b0;
      best_sum_r   <= 35'd0;
      best_idx_r   <= 2'd0;
      frame_prev_r <= 1'b1;
      Read_index   <= 2'd0;
      Hit          <= 1'b0;
      Hit_index    <= 2'd0;
      Busy         <= 1'b0;
`ifdef SPHERE_HIT_SCORE_EN
      Score        <= 16'd0;
`endif
    end else begin
      state_r      <= state_s;
      aim_x_r      <= aim_x_s;
      aim_z_r      <= aim_z_s;
      issue_r      <= issue_s;
      valid_r      <= valid_s;
      best_vld_r   <= best_vld_s;
      best_sum_r   <= best_sum_s;
      best_idx_r   <= best_idx_s;
      frame_prev_r <= Frame_Clk;
      Read_index   <= read_index_s;
      Hit          <= hit_s;
      Hit_index    <= hit_index_s;
      Busy         <= busy_s;
`ifdef SPHERE_HIT_SCORE_EN
      Score        <= score_s;
`endif
    end
  end

endmodule

// File: doc/sphere_hit_scanner.md
Name: sphere_hit_scanner

Overview:
- Initiator on the sphere register interface.
- On a Fire request it scans all 4 spheres through the Read_index/Sphere_pos read port and tests each against a 2-D aim point (lateral x, vertical z).
- It selects the nearest hit and drives Hit/Hit_index back to the sphere register.
- Hit is held until the sphere register consumes it on the next Frame_Clk rising edge.

Parameters:
RADIUS, 240, hit radius in integer world units; hit when dx²+dz² < RADIUS².
DEPTH_MAX, 8000, spheres whose depth integer part exceeds this (signed compare) are never hit.

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Frame_Clk  in  1  frame tick, same signal the sphere register uses; sampled synchronously on Clk
Fire  in  1  shot request, sampled on Clk; honoured only in IDLE
Aim_x  in  16  signed integer lateral aim coordinate, captured with Fire
Aim_z  in  16  signed integer vertical aim coordinate, captured with Fire
Sphere_pos  in  192  {z,depth,x}; each component 64-bit two's complement 32.32 fixed point
curr_index  in  2  index tagging Sphere_pos
Read_index  out  2  sphere select for the read port
Hit  out  1  hit request to the sphere register
Hit_index  out  2  sphere that was hit
Busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state IDLE; Read_index 0; Hit 0; Hit_index 0; Busy 0; frame-edge history register 1 (no false edge after reset); best-hit tracker cleared.
- Coordinate extraction:
  - x = Sphere_pos[47:32], depth = Sphere_pos[111:96], z = Sphere_pos[175:160], each a signed 16-bit integer part.
  - dx = x − Aim_x and dz = z − Aim_z, each 17-bit signed.
  - Squares are 34-bit unsigned; the sum is 35-bit unsigned. Compare against RADIUS² as 35-bit. No truncation.
- Read port contract: Sphere_pos/curr_index are valid one Clk after Read_index is driven. Evaluate using curr_index as the tag, not a local counter.
- States:
  - IDLE: Fire=1 captures Aim_x/Aim_z, clears the tracker, goes to SCAN, index counter = 0.
  - SCAN:
    - Read_index = counter. The counter increments each cycle for 4 cycles (0,1,2,3).
    - A valid flag, delayed one cycle from each issue, marks the sample edges.
    - At each valid edge: candidate = (sum < RADIUS²) && (depth ≤ DEPTH_MAX). A candidate replaces the best if no best exists or its sum is strictly smaller. Ties go to the lower index.
    - At the edge evaluating curr_index 3: if a best exists, go to HOLD with Hit=1 and Hit_index=best. Otherwise return to IDLE.
  - HOLD:
    - Hit stays 1 and Hit_index stays stable.
    - The frame rising edge is detected as (Frame_Clk && !Frame_Clk_prev). At the Clk edge where it is true, the sphere register consumes Hit. On that same edge: Hit←0, state←IDLE.
- Latency: Fire sampled at edge E0 → Read_index 0..3 during cycles after E0..E3 → Hit high after E5 (5 Clk).
- Fire while Busy is ignored and not queued. Fire held high re-triggers only after returning to IDLE.
- Aim inputs are ignored except at capture.
- Frame edge during SCAN: not consumed. The HOLD state waits for a subsequent edge.
- Reset mid-scan or in HOLD: immediate return to reset values; Hit drops asynchronously.
- Read_index stays 0 in IDLE/HOLD.

Optional Feature:
SPHERE_HIT_SCORE_EN
- Defined: adds output Score (16-bit, reset 0). It increments by 1 at the edge a hit is consumed in HOLD, and saturates at 16'hFFFF.
- Undefined: no Score port and no counter. Everything else is identical.

Test Plan:
- Aim (0,0), sphere1 at x=100,z=50,depth 3000, others far → Hit=1, Hit_index=1 exactly 5 Clk after Fire; drops on the Clk where the Frame_Clk rising edge is seen.
- Sphere0 at dist² 10000, sphere2 at dist² 400, both within radius → Hit_index=2. Equal dist² on spheres 1 and 3 → Hit_index=1.
- Sphere at x=240,z=0 vs aim (0,0) (sum = RADIUS²) → no Hit, Busy falls after 5 Clk. At x=239 → Hit.
- Sphere inside radius but depth 8001 → no Hit. Depth 8000 → Hit.
- Fire pulsed again during SCAN and HOLD → ignored. Reset asserted in HOLD → Hit, Busy, Read_index = 0 immediately. No spurious frame edge after release with Frame_Clk=1.
- With SPHERE_HIT_SCORE_EN: three consumed hits → Score=3. Preload near 16'hFFFF → saturates.
